// File: rtl/floating_unit.sv
// floating_unit: single-precision IEEE-754 adder/subtractor, one registered stage.
//
// Ports:
//   a, b   : binary32 operands
//   op     : 1 = a + b, 0 = a - b
//   value  : registered binary32 result (round to nearest even, no denormals)
//   debug  : registered {7'b0, raw 25-bit pre-normalisation magnitude}
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//
// Build option: define FLOATING_DEBUG_EN to drive debug; otherwise debug is
// tied to zero and its register is dropped. value is identical either way.
module floating_unit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] value,
  output logic [31:0] debug,
  input  logic        clk,
  input  logic        rst_n
);

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam int unsigned SIG_W  = 24;
  localparam int unsigned EXT_W  = 27;          // significand + guard/round/sticky
  localparam int unsigned SUM_W  = 28;          // extended sum incl. carry-out
  localparam int unsigned SHF_W  = SIG_W + 30;  // alignment scratch width
  localparam int unsigned LZ_W   = 5;
  localparam int unsigned E_W    = 10;          // signed working exponent
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  // Operand decode
  logic [EXP_W-1:0]  w_ea, w_eb;
  logic [FRAC_W-1:0] w_fa, w_fb;
  logic              w_sa, w_sb;
  logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [SIG_W-1:0]  w_sig_a, w_sig_b;

  assign w_ea     = a[30:23];
  assign w_eb     = b[30:23];
  assign w_fa     = a[22:0];
  assign w_fb     = b[22:0];
  assign w_sa     = a[31];
  assign w_sb     = b[31] ^ ~op;
  assign w_a_zero = (w_ea == '0);                // denormals flush to zero
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
  assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
  assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
  assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
  assign w_sig_a  = w_a_zero ? '0 : {1'b1, w_fa};
  assign w_sig_b  = w_b_zero ? '0 : {1'b1, w_fb};

  // Order operands by magnitude (exponent, then significand)
  logic              w_swap, w_sgn_l, w_eff_sub;
  logic [EXP_W-1:0]  w_el, w_es, w_d;
  logic [SIG_W-1:0]  w_sig_l, w_sig_s;

  assign w_swap    = {w_eb, w_sig_b} > {w_ea, w_sig_a};
  assign w_el      = w_swap ? w_eb    : w_ea;
  assign w_es      = w_swap ? w_ea    : w_eb;
  assign w_sig_l   = w_swap ? w_sig_b : w_sig_a;
  assign w_sig_s   = w_swap ? w_sig_a : w_sig_b;
  assign w_sgn_l   = w_swap ? w_sb    : w_sa;
  assign w_d       = w_el - w_es;
  assign w_eff_sub = w_sa ^ w_sb;

  // Align smaller significand, collapsing everything below round into sticky
  logic [SHF_W-1:0] w_align;
  logic [EXT_W-1:0] w_shifted, w_ext;
  logic             w_sticky;

  always_comb begin
    w_align   = {w_sig_s, 30'b0} >> w_d[LZ_W-1:0];
    w_shifted = w_align[SHF_W-1:SHF_W-EXT_W];
    w_sticky  = |w_align[SHF_W-EXT_W-1:0];
    if (w_d >= EXP_W'(EXT_W)) begin
      w_shifted = '0;
      w_sticky  = |w_sig_s;
    end
    w_ext = {w_shifted[EXT_W-1:1], w_shifted[0] | w_sticky};
  end

  // Magnitude add/subtract on the extended significands
  logic [SUM_W-1:0] w_sum;

  assign w_sum = w_eff_sub ? ({1'b0, w_sig_l, 3'b000} - {1'b0, w_ext})
                           : ({1'b0, w_sig_l, 3'b000} + {1'b0, w_ext});

  // Normalise: carry-out shifts right, otherwise strip leading zeros
  logic [LZ_W-1:0]  w_lz;
  logic [EXT_W-1:0] w_norm;
  logic [E_W-1:0]   w_e_norm;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < int'(EXT_W); i++) begin
      if (w_sum[i]) w_lz = LZ_W'(int'(EXT_W) - 1 - i);
    end
    if (w_sum[SUM_W-1]) begin
      w_norm   = {w_sum[SUM_W-1:2], w_sum[1] | w_sum[0]};
      w_e_norm = {2'b00, w_el} + E_W'(1);
    end else begin
      w_norm   = w_sum[EXT_W-1:0] << w_lz;
      w_e_norm = {2'b00, w_el} - {5'b00000, w_lz};
    end
  end

  // Round to nearest, ties to even; a rounding carry bumps the exponent
  logic                w_round_up;
  logic [SIG_W:0]      w_sig_rnd;
  logic [E_W-1:0]      w_e_res;
  logic [FRAC_W-1:0]   w_frac_res;
  logic                w_ovf, w_unf;

  assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
  assign w_sig_rnd  = {1'b0, w_norm[EXT_W-1:3]} + (SIG_W+1)'(w_round_up);
  assign w_e_res    = w_e_norm + E_W'(w_sig_rnd[SIG_W]);
  assign w_frac_res = w_sig_rnd[SIG_W] ? w_sig_rnd[SIG_W-1:1] : w_sig_rnd[FRAC_W-1:0];
  assign w_ovf      = $signed(w_e_res) >= $signed(E_W'(255));
  assign w_unf      = $signed(w_e_res) <= $signed(E_W'(0));

  // Result selection, special cases in priority order
  logic [31:0] w_value_nxt;

  always_comb begin
    w_value_nxt = {w_sgn_l, w_e_res[EXP_W-1:0], w_frac_res};
    if (w_a_nan || w_b_nan) begin
      w_value_nxt = QNAN;
    end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
      w_value_nxt = QNAN;
    end else if (w_a_inf) begin
      w_value_nxt = {w_sa, 8'hFF, 23'b0};
    end else if (w_b_inf) begin
      w_value_nxt = {w_sb, 8'hFF, 23'b0};
    end else if (w_sum == '0) begin
      // Exact cancellation and zero + zero both give +0
      w_value_nxt = 32'h0000_0000;
    end else if (w_ovf) begin
      w_value_nxt = {w_sgn_l, 8'hFF, 23'b0};
    end else if (w_unf) begin
      w_value_nxt = {w_sgn_l, 31'b0};
    end else if (w_a_zero) begin
      w_value_nxt = {w_sb, b[30:0]};
    end else if (w_b_zero) begin
      w_value_nxt = {w_sa, a[30:0]};
    end
  end

  // Result register
  logic [31:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_value <= '0;
    else        r_value <= w_value_nxt;
  end

  assign value = r_value;

`ifdef FLOATING_DEBUG_EN
  // Raw magnitude is only meaningful when the ordinary arithmetic path is used
  logic        w_special_c;
  logic [31:0] r_debug;

  assign w_special_c = w_a_nan | w_b_nan | w_a_inf | w_b_inf | (w_sum == '0) |
                       w_ovf | w_unf | w_a_zero | w_b_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_debug <= '0;
    else if (w_special_c) r_debug <= '0;
    else                  r_debug <= {7'b0, w_sum[SUM_W-1:3]};
  end

  assign debug = r_debug;
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_floating_unit.sv
// Testbench for floating_unit: directed literal vectors plus randomized
// operands checked every cycle against a real-arithmetic reference model.
module tb_floating_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic        op;
  logic [31:0] value, debug;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  floating_unit dut (
    .a     (a),
    .b     (b),
    .op    (op),
    .value (value),
    .debug (debug),
    .clk   (clk),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (a=%08h b=%08h op=%0b)", name, act, expv, a, b, op);
    end
  endtask

  // Normal binary32 -> real, built directly as a double bit pattern
  function automatic real to_real(input logic s, input logic [7:0] e, input logic [22:0] f);
    logic [10:0] de;
    de = 11'(int'(e) - 127 + 1023);
    return $bitstoreal({s, de, f, 29'b0});
  endfunction

  // Reference: exact-enough double sum, rounded once more to binary32 (RNE).
  // Doubles carry > 2*24+2 bits, so this double rounding is innocuous for add.
  task automatic model(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                       output logic [31:0] v, output logic [31:0] dbg);
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        sa, sb, s;
    real         rs;
    logic [63:0] bits;
    int          fe, d;
    logic [23:0] mant;
    logic [28:0] rem;
    longint      lsig, ssig, fl, cl, raw;
    ea = ia[30:23]; fa = ia[22:0]; sa = ia[31];
    eb = ib[30:23]; fb = ib[22:0]; sb = ib[31] ^ ~iop;
    dbg = 32'h0;
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) begin
      v = 32'h7FC00000; return;
    end
    if (ea == 8'hFF && eb == 8'hFF && sa != sb) begin
      v = 32'h7FC00000; return;
    end
    if (ea == 8'hFF) begin v = {sa, 8'hFF, 23'b0}; return; end
    if (eb == 8'hFF) begin v = {sb, 8'hFF, 23'b0}; return; end
    if (ea == 0 && eb == 0) begin v = 32'h0; return; end
    if (ea == 0) begin v = {sb, ib[30:0]}; return; end
    if (eb == 0) begin v = {sa, ia[30:0]}; return; end
    rs = to_real(sa, ea, fa) + to_real(sb, eb, fb);
    if (rs == 0.0) begin v = 32'h0; return; end
    bits = $realtobits(rs);
    s    = bits[63];
    fe   = int'(bits[62:52]) - 1023 + 127;
    if (fe <= 0) begin v = {s, 31'b0}; return; end
    mant = {1'b1, bits[51:29]};
    rem  = bits[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mant[0])) begin
      if (mant == 24'hFFFFFF) begin mant = 24'h800000; fe++; end
      else mant++;
    end
    if (fe >= 255) begin v = {s, 8'hFF, 23'b0}; return; end
    v = {s, 8'(fe), mant[22:0]};
    // Raw magnitude: truncated sum, or larger minus the ceiling of the aligned smaller
    if (ia[30:0] >= ib[30:0]) begin
      lsig = longint'({1'b1, fa}); ssig = longint'({1'b1, fb}); d = int'(ea) - int'(eb);
    end else begin
      lsig = longint'({1'b1, fb}); ssig = longint'({1'b1, fa}); d = int'(eb) - int'(ea);
    end
    if (d > 40) begin
      fl = 0; cl = 1;
    end else begin
      fl = ssig >> d;
      cl = (ssig + (longint'(1) << d) - 1) >> d;
    end
    raw = (sa == sb) ? lsig + fl : lsig - cl;
`ifdef FLOATING_DEBUG_EN
    dbg = 32'(raw);
`else
    dbg = 32'h0;
    if (raw < 0) dbg = 32'h0;
`endif
  endtask

  // Expected outputs, registered like the spec's one-cycle latency
  logic [31:0] exp_v, exp_d, m_v, m_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_v <= 32'h0;
      exp_d <= 32'h0;
    end else begin
      model(a, b, op, m_v, m_d);
      exp_v <= m_v;
      exp_d <= m_d;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("value_cycle", value, exp_v);
      check("debug_cycle", debug, exp_d);
    end
  end

  function automatic logic [31:0] dbg_lit(input logic [31:0] x);
`ifdef FLOATING_DEBUG_EN
    return x;
`else
    return (x == 32'hFFFFFFFF) ? 32'h0 : 32'h0;
`endif
  endfunction

  task automatic apply(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                       input logic [31:0] ev, input logic [31:0] ed, input string name);
    @(negedge clk);
    a = ia; b = ib; op = iop;
    @(posedge clk);
    #1;
    check(name, value, ev);
    check(name, debug, dbg_lit(ed));
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0:       r[30:0] = 31'h0;                              // zero
      1:       r[30:23] = 8'h00;                             // denormal
      2:       r[30:0] = {8'hFF, 23'h0};                     // inf
      3:       r[30:23] = 8'hFF;                             // NaN (usually)
      4:       r[30:23] = 8'(250 + $urandom_range(0, 4));    // near overflow
      5:       r[30:23] = 8'(1 + $urandom_range(0, 4));      // near underflow
      default: r[30:23] = 8'(1 + $urandom_range(0, 253));
    endcase
    return r;
  endfunction

  logic [31:0] pv, pd;

  initial begin
    rst_n = 1'b0;
    a = 32'h0; b = 32'h0; op = 1'b0;
    #1;
    check("reset_value", value, 32'h0);
    check("reset_debug", debug, 32'h0);

    // Pin the reference model with hand-computed results
    model(32'h447A0000, 32'hC1200000, 1'b1, pv, pd);
    check("pin_990", pv, 32'h44778000);
    model(32'h3F800000, 32'h33C00000, 1'b1, pv, pd);
    check("pin_round_up", pv, 32'h3F800001);
    model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, pv, pd);
    check("pin_overflow", pv, 32'h7F800000);
    model(32'h40A00000, 32'h40A00000, 1'b0, pv, pd);
    check("pin_cancel", pv, 32'h00000000);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_en = 1'b1;

    apply(32'h447A0000, 32'hC1200000, 1'b1, 32'h44778000, 32'h00F78000, "sub_990");
    apply(32'h447A0000, 32'hC1200000, 1'b0, 32'h447C8000, 32'h00FC8000, "add_1010");
    apply(32'h42000000, 32'h42000000, 1'b1, 32'h42800000, 32'h01000000, "carry_64");
    apply(32'h40A00000, 32'h40A00000, 1'b0, 32'h00000000, 32'h00000000, "cancel");
    apply(32'h7F800000, 32'hFF800000, 1'b1, 32'h7FC00000, 32'h00000000, "inf_minus_inf");
    apply(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 32'h7F800000, 32'h00000000, "overflow");
    apply(32'h3F800000, 32'h33800000, 1'b1, 32'h3F800000, 32'h00800000, "tie_even_down");
    apply(32'h3F800001, 32'h33800000, 1'b1, 32'h3F800002, 32'h00800001, "tie_even_up");
    apply(32'h00800001, 32'h00800000, 1'b0, 32'h00000000, 32'h00000000, "underflow");
    apply(32'h00000000, 32'h40A00000, 1'b0, 32'hC0A00000, 32'h00000000, "zero_minus_x");
    apply(32'h00000001, 32'h3F800000, 1'b1, 32'h3F800000, 32'h00000000, "denorm_flush");
    apply(32'h7FC00001, 32'h3F800000, 1'b1, 32'h7FC00000, 32'h00000000, "nan_in");
    apply(32'h3F800000, 32'h7F800000, 1'b0, 32'hFF800000, 32'h00000000, "minus_inf");

    // Asynchronous reset between edges clears outputs immediately
    apply(32'h447A0000, 32'hC1200000, 1'b1, 32'h44778000, 32'h00F78000, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_value", value, 32'h0);
    check("async_reset_debug", debug, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_value", value, 32'h44778000);
    check("post_reset_debug", debug, dbg_lit(32'h00F78000));

    // Randomized traffic; junk driven mid-cycle must not matter
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      a  = rand_operand();
      op = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       b = a ^ {1'($urandom), 30'h0, 1'($urandom)};        // near cancellation
        1, 2:    b = {1'($urandom), 8'(int'(a[30:23]) ^ $urandom_range(0, 1)), 23'($urandom)};
        default: b = rand_operand();
      endcase
      @(posedge clk);
      #2;
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom; b = $urandom; op = 1'($urandom);
      end
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
